lsu_completion_tracker: RTL and testbench

//  Completion-side counterpart of the warp scheduler's issue path. Each memory op the scheduler

---
 rtl/lsu_completion_tracker_pkg.sv | 20 ++
 rtl/lsu_completion_tracker_if.sv | 41 ++++
 rtl/lsu_completion_tracker_completion_fifo.sv | 49 ++++
 rtl/lsu_completion_tracker.sv | 103 ++++++++++
 tb/tb_lsu_completion_tracker.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_completion_tracker_pkg.sv
// Shared widths and the logged-op record for the LSU completion tracker.
package lsu_completion_tracker_pkg;
  localparam int DATA_WIDTH  = 16;
  localparam int NUM_THREADS = 32;
  localparam int DEPTH       = 4;
  localparam int WARP_ID_W   = 2;
  localparam int REG_ADDR_W  = 4;
  localparam int PTR_W       = $clog2(DEPTH);
  localparam int CNT_W       = PTR_W + 1;
  localparam int LANES_W     = NUM_THREADS * DATA_WIDTH;

  typedef struct packed {
    logic [WARP_ID_W-1:0]   warp;
    logic [NUM_THREADS-1:0] mask;
    logic [REG_ADDR_W-1:0]  target_reg;
    logic                   is_load;
  } entry_t;

  localparam int ENTRY_W = $bits(entry_t);
endpackage

// File: rtl/lsu_completion_tracker_if.sv
// Issue, memory-response and completion signals between scheduler/LSU and the tracker.
interface lsu_completion_tracker_if;
  import lsu_completion_tracker_pkg::*;

  logic                   issue_valid;
  logic                   issue_ready;
  logic [WARP_ID_W-1:0]   issue_warp;
  logic [NUM_THREADS-1:0] issue_mask;
  logic [REG_ADDR_W-1:0]  issue_target_reg;
  logic                   issue_is_load;

  logic                   mem_rsp_valid;
  logic                   mem_rsp_ready;
  logic [LANES_W-1:0]     mem_rsp_data;

  logic                   wb_en;
  logic [WARP_ID_W-1:0]   wb_warp;
  logic [REG_ADDR_W-1:0]  wb_reg;
  logic [NUM_THREADS-1:0] wb_mask;
  logic [LANES_W-1:0]     wb_data;
  logic                   done_bit;
  logic [WARP_ID_W-1:0]   warp_num_clear;
  logic [NUM_THREADS-1:0] threads_mask_clear;
  logic [CNT_W-1:0]       outstanding;

  modport master (
    output issue_valid, issue_warp, issue_mask, issue_target_reg, issue_is_load,
    output mem_rsp_valid, mem_rsp_data,
    input  issue_ready, mem_rsp_ready,
    input  wb_en, wb_warp, wb_reg, wb_mask, wb_data,
    input  done_bit, warp_num_clear, threads_mask_clear, outstanding
  );

  modport slave (
    input  issue_valid, issue_warp, issue_mask, issue_target_reg, issue_is_load,
    input  mem_rsp_valid, mem_rsp_data,
    output issue_ready, mem_rsp_ready,
    output wb_en, wb_warp, wb_reg, wb_mask, wb_data,
    output done_bit, warp_num_clear, threads_mask_clear, outstanding
  );
endinterface

// File: rtl/lsu_completion_tracker_completion_fifo.sv
// In-order log of issued memory ops; the head entry is visible combinationally for the pop.
module completion_fifo
  import lsu_completion_tracker_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  entry_t           din,
  output entry_t           head,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             push_ok;
  logic             pop_ok;
  entry_t           mem [DEPTH];

  assign full    = (count_reg == CNT_W'(DEPTH));
  assign empty   = (count_reg == '0);
  assign count   = count_reg;
  assign head    = mem[rd_ptr_reg];
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_reg] <= din;
  end
endmodule

// File: rtl/lsu_completion_tracker.sv
// Logs issued memory ops in order and turns each in-order response into a registered
// register-file writeback (loads) and scoreboard clear one cycle later.
module lsu_completion_tracker
  import lsu_completion_tracker_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  lsu_completion_tracker_if.slave  bus
);
  entry_t           issue_entry;
  entry_t           head;
  logic             full;
  logic             empty;
  logic [CNT_W-1:0] count;
  logic             issue_fire;
  logic             rsp_fire;

  logic                   done_reg,       done_next;
  logic [WARP_ID_W-1:0]   clear_warp_reg, clear_warp_next;
  logic [NUM_THREADS-1:0] clear_mask_reg, clear_mask_next;
  logic                   wb_en_reg,      wb_en_next;
  logic [WARP_ID_W-1:0]   wb_warp_reg,    wb_warp_next;
  logic [REG_ADDR_W-1:0]  wb_dst_reg,     wb_dst_next;
  logic [NUM_THREADS-1:0] wb_mask_reg,    wb_mask_next;
  logic [LANES_W-1:0]     wb_data_reg,    wb_data_next;

  assign issue_entry = '{warp:       bus.issue_warp,
                         mask:       bus.issue_mask,
                         target_reg: bus.issue_target_reg,
                         is_load:    bus.issue_is_load};

  // Readies come from the registered occupancy only, so a pop never frees a slot same-cycle.
  assign issue_fire = bus.issue_valid && !full;
  assign rsp_fire   = bus.mem_rsp_valid && !empty;

  completion_fifo u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (issue_fire),
    .pop   (rsp_fire),
    .din   (issue_entry),
    .head  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  always_comb begin
    done_next       = rsp_fire;
    clear_warp_next = '0;
    clear_mask_next = '0;
    wb_en_next      = 1'b0;
    wb_warp_next    = '0;
    wb_dst_next     = '0;
    wb_mask_next    = '0;
    wb_data_next    = '0;
    if (rsp_fire) begin
      clear_warp_next = head.warp;
      clear_mask_next = head.mask;
      if (head.is_load) begin
        wb_en_next   = 1'b1;
        wb_warp_next = head.warp;
        wb_dst_next  = head.target_reg;
        wb_mask_next = head.mask;
        wb_data_next = bus.mem_rsp_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      done_reg       <= 1'b0;
      clear_warp_reg <= '0;
      clear_mask_reg <= '0;
      wb_en_reg      <= 1'b0;
      wb_warp_reg    <= '0;
      wb_dst_reg     <= '0;
      wb_mask_reg    <= '0;
      wb_data_reg    <= '0;
    end else begin
      done_reg       <= done_next;
      clear_warp_reg <= clear_warp_next;
      clear_mask_reg <= clear_mask_next;
      wb_en_reg      <= wb_en_next;
      wb_warp_reg    <= wb_warp_next;
      wb_dst_reg     <= wb_dst_next;
      wb_mask_reg    <= wb_mask_next;
      wb_data_reg    <= wb_data_next;
    end
  end

  assign bus.issue_ready        = !full;
  assign bus.mem_rsp_ready      = !empty;
  assign bus.outstanding        = count;
  assign bus.done_bit           = done_reg;
  assign bus.warp_num_clear     = clear_warp_reg;
  assign bus.threads_mask_clear = clear_mask_reg;
  assign bus.wb_en              = wb_en_reg;
  assign bus.wb_warp            = wb_warp_reg;
  assign bus.wb_reg             = wb_dst_reg;
  assign bus.wb_mask            = wb_mask_reg;
  assign bus.wb_data            = wb_data_reg;
endmodule

// File: tb/tb_lsu_completion_tracker.sv
// Directed vector table, hand-written reset/early-response sequences and a random run
// checked against a queue-based model of the in-order completion tracker.
module tb_lsu_completion_tracker;
  import lsu_completion_tracker_pkg::*;

  localparam int W = LANES_W;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  lsu_completion_tracker_if bus();

  lsu_completion_tracker dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        iv;
    logic [1:0]  w;
    logic [31:0] m;
    logic [3:0]  r;
    logic        ld;
    logic        rv;
    logic [15:0] ds;
    logic        e_ir;
    logic        e_rr;
    logic        e_done;
    logic        e_wb;
    logic [1:0]  e_w;
    logic [31:0] e_m;
    logic [3:0]  e_r;
    logic [2:0]  e_out;
  } vec_t;

  typedef struct {
    logic [1:0]  w;
    logic [31:0] m;
    logic [3:0]  r;
    logic        ld;
  } op_t;

  vec_t tbl[$];
  op_t  model_q[$];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] mk_data(input logic [15:0] seed);
    logic [W-1:0] d;
    d = '0;
    for (int t = 0; t < NUM_THREADS; t++) d[t*DATA_WIDTH +: DATA_WIDTH] = seed + 16'(t);
    return d;
  endfunction

  task automatic add(input int iv, input int w, input logic [31:0] m, input int r, input int ld,
                     input int rv, input int ds, input int e_ir, input int e_rr,
                     input int e_done, input int e_wb, input int e_w, input logic [31:0] e_m,
                     input int e_r, input int e_out);
    vec_t v;
    v.iv = 1'(iv);  v.w = 2'(w);  v.m = m;  v.r = 4'(r);  v.ld = 1'(ld);
    v.rv = 1'(rv);  v.ds = 16'(ds);
    v.e_ir = 1'(e_ir);  v.e_rr = 1'(e_rr);  v.e_done = 1'(e_done);  v.e_wb = 1'(e_wb);
    v.e_w = 2'(e_w);  v.e_m = e_m;  v.e_r = 4'(e_r);  v.e_out = 3'(e_out);
    tbl.push_back(v);
  endtask

  task automatic drive(input logic iv, input logic [1:0] w, input logic [31:0] m,
                       input logic [3:0] r, input logic ld, input logic rv, input logic [W-1:0] d);
    bus.issue_valid      = iv;
    bus.issue_warp       = w;
    bus.issue_mask       = m;
    bus.issue_target_reg = r;
    bus.issue_is_load    = ld;
    bus.mem_rsp_valid    = rv;
    bus.mem_rsp_data     = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t v;
    op_t  op;
    op_t  exp_op;
    logic exp_done;
    logic iv, rv, ld;
    logic [1:0] w;
    logic [31:0] m;
    logic [3:0] r;
    logic [W-1:0] d;
    int sz;

    // Reset held 3 cycles with both valids asserted: nothing may be logged.
    drive(1'b1, 2'd1, 32'hFFFF_FFFF, 4'd1, 1'b1, 1'b1, mk_data(16'h0AAA));
    reset = 1'b0;
    repeat (3) tick();
    check("reset_done", W'(bus.done_bit), W'(0));
    check("reset_wb_en", W'(bus.wb_en), W'(0));
    check("reset_outstanding", W'(bus.outstanding), W'(0));
    check("reset_issue_ready", W'(bus.issue_ready), W'(1));
    check("reset_rsp_ready", W'(bus.mem_rsp_ready), W'(0));
    check("reset_wb_data", bus.wb_data, W'(0));
    drive(1'b0, 2'd0, 32'h0, 4'd0, 1'b0, 1'b0, W'(0));
    reset = 1'b1;
    tick();
    check("post_reset_outstanding", W'(bus.outstanding), W'(0));

    // iv w m r ld | rv ds | ir rr | done wb warp mask reg | out
    add(1,2,'h0000FFFF,5,1, 0,0,      1,0, 0,0,0,0,0, 1);
    add(0,0,0,0,0,          1,'h1000, 1,1, 1,1,2,'h0000FFFF,5, 0);
    add(1,1,'hFFFF0000,3,0, 0,0,      1,0, 0,0,0,0,0, 1);
    add(0,0,0,0,0,          1,'h2000, 1,1, 1,0,1,'hFFFF0000,3, 0);
    add(1,0,'h1,1,1,        0,0,      1,0, 0,0,0,0,0, 1);
    add(1,1,'h2,2,1,        0,0,      1,1, 0,0,0,0,0, 2);
    add(1,2,'h4,3,0,        0,0,      1,1, 0,0,0,0,0, 3);
    add(1,3,'h8,4,1,        0,0,      1,1, 0,0,0,0,0, 4);
    add(1,0,'hF,9,1,        0,0,      0,1, 0,0,0,0,0, 4);
    add(0,0,0,0,0,          1,'h3000, 0,1, 1,1,0,'h1,1, 3);
    add(0,0,0,0,0,          1,'h3100, 1,1, 1,1,1,'h2,2, 2);
    add(0,0,0,0,0,          1,'h3200, 1,1, 1,0,2,'h4,3, 1);
    add(0,0,0,0,0,          1,'h3300, 1,1, 1,1,3,'h8,4, 0);
    add(1,0,'h10,6,1,       0,0,      1,0, 0,0,0,0,0, 1);
    add(1,1,'h20,7,1,       0,0,      1,1, 0,0,0,0,0, 2);
    add(1,2,'h40,8,1,       0,0,      1,1, 0,0,0,0,0, 3);
    add(1,3,'h80,9,1,       0,0,      1,1, 0,0,0,0,0, 4);
    add(1,2,'h100,10,1,     1,'h4000, 0,1, 1,1,0,'h10,6, 3);
    add(1,2,'h100,10,1,     0,0,      1,1, 0,0,0,0,0, 4);
    add(0,0,0,0,0,          1,'h4100, 0,1, 1,1,1,'h20,7, 3);
    add(1,0,'h10000,11,1,   1,'h4200, 1,1, 1,1,2,'h40,8, 3);
    add(1,1,'h20000,12,0,   1,'h4300, 1,1, 1,1,3,'h80,9, 3);
    add(1,2,'h40000,13,1,   1,'h4400, 1,1, 1,1,2,'h100,10, 3);
    add(1,3,'h80000,14,1,   1,'h4500, 1,1, 1,1,0,'h10000,11, 3);
    add(1,0,'h100000,15,1,  1,'h4600, 1,1, 1,0,1,'h20000,12, 3);
    add(1,1,'h200000,0,1,   1,'h4700, 1,1, 1,1,2,'h40000,13, 3);
    add(0,0,0,0,0,          1,'h4800, 1,1, 1,1,3,'h80000,14, 2);
    add(0,0,0,0,0,          1,'h4900, 1,1, 1,1,0,'h100000,15, 1);
    add(0,0,0,0,0,          1,'h4A00, 1,1, 1,1,1,'h200000,0, 0);

    foreach (tbl[i]) begin
      v = tbl[i];
      drive(v.iv, v.w, v.m, v.r, v.ld, v.rv, mk_data(v.ds));
      check("vec_issue_ready", W'(bus.issue_ready), W'(v.e_ir));
      check("vec_rsp_ready", W'(bus.mem_rsp_ready), W'(v.e_rr));
      tick();
      $display("vec %0d: iv=%0b rv=%0b done=%0b wb_en=%0b warp=%0d out=%0d",
               i, v.iv, v.rv, bus.done_bit, bus.wb_en, bus.warp_num_clear, bus.outstanding);
      check("vec_done", W'(bus.done_bit), W'(v.e_done));
      check("vec_wb_en", W'(bus.wb_en), W'(v.e_wb));
      check("vec_outstanding", W'(bus.outstanding), W'(v.e_out));
      if (v.e_done) begin
        check("vec_warp_clear", W'(bus.warp_num_clear), W'(v.e_w));
        check("vec_mask_clear", W'(bus.threads_mask_clear), W'(v.e_m));
        check("vec_wb_warp", W'(bus.wb_warp), v.e_wb ? W'(v.e_w) : W'(0));
        check("vec_wb_reg", W'(bus.wb_reg), v.e_wb ? W'(v.e_r) : W'(0));
        check("vec_wb_mask", W'(bus.wb_mask), v.e_wb ? W'(v.e_m) : W'(0));
        check("vec_wb_data", bus.wb_data, v.e_wb ? mk_data(v.ds) : W'(0));
      end
    end

    // Early response while empty: held off until the op has been logged for a cycle.
    drive(1'b0, 2'd0, 32'h0, 4'd0, 1'b0, 1'b1, mk_data(16'h5000));
    repeat (2) begin
      check("early_rsp_ready", W'(bus.mem_rsp_ready), W'(0));
      tick();
      check("early_done", W'(bus.done_bit), W'(0));
      check("early_outstanding", W'(bus.outstanding), W'(0));
    end
    drive(1'b1, 2'd3, 32'h0000_AAAA, 4'd2, 1'b1, 1'b1, mk_data(16'h5000));
    check("early_same_cycle_ready", W'(bus.mem_rsp_ready), W'(0));
    tick();
    check("early_issue_done", W'(bus.done_bit), W'(0));
    check("early_issue_outstanding", W'(bus.outstanding), W'(1));
    drive(1'b0, 2'd0, 32'h0, 4'd0, 1'b0, 1'b1, mk_data(16'h5000));
    check("early_next_ready", W'(bus.mem_rsp_ready), W'(1));
    tick();
    check("early_accept_done", W'(bus.done_bit), W'(1));
    check("early_accept_warp", W'(bus.warp_num_clear), W'(3));
    check("early_accept_data", bus.wb_data, mk_data(16'h5000));
    check("early_accept_outstanding", W'(bus.outstanding), W'(0));

    // Reset with two ops outstanding drops them silently.
    drive(1'b1, 2'd1, 32'h1, 4'd1, 1'b1, 1'b0, W'(0));
    tick();
    drive(1'b1, 2'd2, 32'h2, 4'd2, 1'b0, 1'b0, W'(0));
    tick();
    check("midreset_before", W'(bus.outstanding), W'(2));
    drive(1'b0, 2'd0, 32'h0, 4'd0, 1'b0, 1'b0, W'(0));
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check("midreset_outstanding", W'(bus.outstanding), W'(0));
    check("midreset_issue_ready", W'(bus.issue_ready), W'(1));
    check("midreset_rsp_ready", W'(bus.mem_rsp_ready), W'(0));
    drive(1'b0, 2'd0, 32'h0, 4'd0, 1'b0, 1'b1, mk_data(16'h6000));
    repeat (3) begin
      tick();
      check("midreset_no_done", W'(bus.done_bit), W'(0));
      check("midreset_no_wb", W'(bus.wb_en), W'(0));
    end

    // Random traffic against the in-order queue model.
    model_q.delete();
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (cyc < 200) begin
        iv = ($urandom_range(0, 3) != 0);
        rv = 1'($urandom_range(0, 1));
      end else begin
        iv = ($urandom_range(0, 2) == 0);
        rv = ($urandom_range(0, 3) != 0);
      end
      w  = 2'($urandom);
      m  = $urandom;
      r  = 4'($urandom);
      ld = 1'($urandom);
      for (int t = 0; t < NUM_THREADS; t++) d[t*DATA_WIDTH +: DATA_WIDTH] = 16'($urandom);
      drive(iv, w, m, r, ld, rv, d);

      sz = model_q.size();
      check("rnd_issue_ready", W'(bus.issue_ready), W'(sz != DEPTH));
      check("rnd_rsp_ready", W'(bus.mem_rsp_ready), W'(sz != 0));
      exp_done = rv && (sz > 0);
      exp_op   = '{w: 2'd0, m: 32'h0, r: 4'd0, ld: 1'b0};
      if (exp_done) exp_op = model_q.pop_front();
      if (iv && (sz < DEPTH)) begin
        op = '{w: w, m: m, r: r, ld: ld};
        model_q.push_back(op);
      end

      tick();
      check("rnd_done", W'(bus.done_bit), W'(exp_done));
      check("rnd_wb_en", W'(bus.wb_en), W'(exp_done && exp_op.ld));
      check("rnd_outstanding", W'(bus.outstanding), W'(model_q.size()));
      if (exp_done) begin
        $display("rnd txn cyc=%0d: warp=%0d mask=%h load=%0b", cyc, exp_op.w, exp_op.m, exp_op.ld);
        check("rnd_warp_clear", W'(bus.warp_num_clear), W'(exp_op.w));
        check("rnd_mask_clear", W'(bus.threads_mask_clear), W'(exp_op.m));
        check("rnd_wb_reg", W'(bus.wb_reg), exp_op.ld ? W'(exp_op.r) : W'(0));
        check("rnd_wb_warp", W'(bus.wb_warp), exp_op.ld ? W'(exp_op.w) : W'(0));
        check("rnd_wb_mask", W'(bus.wb_mask), exp_op.ld ? W'(exp_op.m) : W'(0));
        check("rnd_wb_data", bus.wb_data, exp_op.ld ? d : W'(0));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
